// File: rtl/magic_nor_exec.sv
// ============================================================================
// Module   : magic_nor_exec
// Brief    : Sequential NOR-netlist executor over a MAGIC memristor row.
//            Each nor1/nor2 gate runs as INIT (dst <= 1) then NOR EVAL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module magic_nor_exec #(
    parameter int NCELLS = 32,
    parameter int AW     = 5,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [1:0]    instr_op,
    input  logic [AW-1:0] instr_a,
    input  logic [AW-1:0] instr_b,
    input  logic [AW-1:0] instr_dst,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] gate_cnt
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_init = 2'd1;
    localparam logic [1:0] c_st_eval = 2'd2;

    localparam logic [1:0] c_op_nor2 = 2'b01;
    localparam logic [1:0] c_op_halt = 2'b11;

    localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [NCELLS-1:0] r_cells;
    logic [AW-1:0]     r_a;
    logic [AW-1:0]     r_b;
    logic [AW-1:0]     r_dst;
    logic              r_is_nor2;
    logic              r_done;
    logic              r_err;
    logic              r_rd_data;
    logic [CW-1:0]     r_gate_cnt;

    logic w_accept;
    logic w_is_gate;
    logic w_inplace;
    logic w_start;
    logic w_eval_bit;

    assign w_accept   = instr_valid & instr_ready;
    assign w_is_gate  = w_accept & ~instr_op[1];
    // MAGIC cannot evaluate onto one of its own inputs; such gates are dropped.
    assign w_inplace  = w_is_gate & ((instr_dst == instr_a) |
                        ((instr_op == c_op_nor2) & (instr_dst == instr_b)));
    assign w_start    = w_is_gate & ~w_inplace;
    assign w_eval_bit = r_cells[r_dst] & ~(r_cells[r_a] | (r_is_nor2 & r_cells[r_b]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_start) w_next_state = c_st_init;
            c_st_init: w_next_state = c_st_eval;
            c_st_eval: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    // Ready is masked by rst so it reads low for the whole reset window.
    always_comb begin
        instr_ready = (r_state == c_st_idle) & ~rst;
        busy        = (r_state == c_st_init) | (r_state == c_st_eval);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cells    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_dst      <= '0;
            r_is_nor2  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_data  <= 1'b0;
            r_gate_cnt <= '0;
        end else begin
            r_done    <= w_accept & (instr_op == c_op_halt);
            r_rd_data <= r_cells[rd_addr];
            if (w_inplace) begin
                r_err <= 1'b1;
            end
            if (w_start) begin
                r_a       <= instr_a;
                r_b       <= instr_b;
                r_dst     <= instr_dst;
                r_is_nor2 <= (instr_op == c_op_nor2);
            end
            case (r_state)
                c_st_idle: begin
                    if (wr_en) begin
                        r_cells[wr_addr] <= wr_data;
                    end
                end
                c_st_init: begin
                    r_cells[r_dst] <= 1'b1;
                end
                c_st_eval: begin
                    r_cells[r_dst] <= w_eval_bit;
                    if (r_gate_cnt != c_cnt_max) begin
                        r_gate_cnt <= r_gate_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_data  = r_rd_data;
    assign done     = r_done;
    assign err      = r_err;
    assign gate_cnt = r_gate_cnt;

endmodule

`default_nettype wire

// File: tb/tb_magic_nor_exec.sv
// ============================================================================
// Module   : tb_magic_nor_exec
// Brief    : Scoreboard bench for magic_nor_exec (XOR, 5-input parity,
//            handshake, in-place error, saturation, blocked write, reset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_magic_nor_exec;

    localparam logic [1:0] c_nor1 = 2'b00;
    localparam logic [1:0] c_nor2 = 2'b01;
    localparam logic [1:0] c_nop  = 2'b10;
    localparam logic [1:0] c_halt = 2'b11;

    typedef struct {
        logic  exp;
        string name;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic        wr_data = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [1:0]  instr_op = c_nop;
    logic [4:0]  instr_a = '0;
    logic [4:0]  instr_b = '0;
    logic [4:0]  instr_dst = '0;
    logic [4:0]  rd_addr = '0;
    logic        rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] gate_cnt;

    logic        sat_ready;
    logic        sat_rd_data;
    logic        sat_busy;
    logic        sat_done;
    logic        sat_err;
    logic [3:0]  sat_cnt;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int exp_cnt = 0;
    logic rd_req = 1'b0;
    logic rd_req_d = 1'b0;
    sb_item_t sb[$];
    sb_item_t item;

    magic_nor_exec #(.NCELLS(32), .AW(5), .CW(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_a(instr_a), .instr_b(instr_b), .instr_dst(instr_dst),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .err(err), .gate_cnt(gate_cnt)
    );

    // Narrow-counter copy sees the same stream to exercise saturation.
    magic_nor_exec #(.NCELLS(32), .AW(5), .CW(4)) dut_sat (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .instr_valid(instr_valid), .instr_ready(sat_ready), .instr_op(instr_op),
        .instr_a(instr_a), .instr_b(instr_b), .instr_dst(instr_dst),
        .rd_addr(rd_addr), .rd_data(sat_rd_data), .busy(sat_busy), .done(sat_done),
        .err(sat_err), .gate_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        if (done) done_seen++;
        if (rd_req_d) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: rd_data=%0d with no expectation queued", rd_data);
            end else begin
                item = sb.pop_front();
                if (rd_data !== item.exp) begin
                    bad++;
                    $display("FAIL %s: rd_data=%0d want %0d", item.name, rd_data, item.exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic val);
        wr_en = 1'b1; wr_addr = addr; wr_data = val;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read(input logic [4:0] addr, input logic exp, input string name);
        sb_item_t it;
        it.exp = exp; it.name = name;
        sb.push_back(it);
        rd_addr = addr; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    // Returns just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] dst);
        bit ok;
        ok = 1'b0;
        instr_valid = 1'b1; instr_op = op; instr_a = a; instr_b = b; instr_dst = dst;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = instr_ready;
            tick();
        end
        instr_valid = 1'b0;
        if (!ok) check("issue_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (instr_ready) ok = 1'b1;
            else tick();
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic xor_stage(input logic [4:0] p, input logic [4:0] q, input logic [4:0] base);
        issue(c_nor2, p, q, base);
        issue(c_nor2, p, base, base + 5'd1);
        issue(c_nor2, q, base, base + 5'd2);
        issue(c_nor2, base + 5'd1, base + 5'd2, base + 5'd3);
        issue(c_nor1, base + 5'd3, 5'd0, base + 5'd4);
    endtask

    logic [1:0] hs_op  [8];
    logic [4:0] hs_a   [8];
    logic [4:0] hs_b   [8];
    logic [4:0] hs_dst [8];
    int         hs_acc [8];

    initial begin
        logic x0, x1;
        logic [4:0] xv;
        int idx;

        // Reset state
        tick();
        check("rst_ready", instr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cnt", gate_cnt, 0);
        check("rst_rd", rd_data, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", instr_ready, 1);

        // Dirty the state, then reset in the middle of a gate
        wr(5'd0, 1'b1);
        wr(5'd1, 1'b1);
        issue(c_nor2, 5'd0, 5'd1, 5'd0);
        issue(c_nor1, 5'd1, 5'd0, 5'd3);
        wait_idle();
        rd_addr = 5'd1;
        tick();
        issue(c_nor1, 5'd2, 5'd0, 5'd9);
        check("mid_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_ready", instr_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", err, 0);
        check("midrst_cnt", gate_cnt, 0);
        check("midrst_rd", rd_data, 0);
        check("midrst_done", done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_ready_after", instr_ready, 1);
        for (int c = 0; c < 32; c++) read(5'(c), 1'b0, "rst_cell_zero");
        exp_cnt = 0;

        // 2-input XOR netlist; c6 holds the XOR, the trailing nor1 inverts it into c7
        for (int v = 0; v < 4; v++) begin
            x0 = v[0]; x1 = v[1];
            wr(5'd0, x0);
            wr(5'd1, x1);
            issue(c_nor2, 5'd1, 5'd0, 5'd2);
            issue(c_nor1, 5'd0, 5'd0, 5'd3);
            issue(c_nor1, 5'd1, 5'd0, 5'd4);
            issue(c_nor2, 5'd4, 5'd3, 5'd5);
            issue(c_nor2, 5'd5, 5'd2, 5'd6);
            issue(c_nor1, 5'd6, 5'd0, 5'd7);
            wait_idle();
            exp_cnt += 6;
            read(5'd6, x0 ^ x1, "xor_c6");
            read(5'd7, ~(x0 ^ x1), "xor_c7");
            check("xor_cnt", gate_cnt, exp_cnt);
        end
        check("sat_cnt", sat_cnt, 15);

        // Handshake with instr_valid held high; nops interleaved
        wr(5'd0, 1'b1);
        wr(5'd1, 1'b0);
        hs_op[0]=c_nor2; hs_a[0]=5'd1; hs_b[0]=5'd0; hs_dst[0]=5'd2;
        hs_op[1]=c_nop;  hs_a[1]=5'd0; hs_b[1]=5'd0; hs_dst[1]=5'd0;
        hs_op[2]=c_nor1; hs_a[2]=5'd0; hs_b[2]=5'd0; hs_dst[2]=5'd3;
        hs_op[3]=c_nor1; hs_a[3]=5'd1; hs_b[3]=5'd0; hs_dst[3]=5'd4;
        hs_op[4]=c_nop;  hs_a[4]=5'd0; hs_b[4]=5'd0; hs_dst[4]=5'd0;
        hs_op[5]=c_nor2; hs_a[5]=5'd4; hs_b[5]=5'd3; hs_dst[5]=5'd5;
        hs_op[6]=c_nor2; hs_a[6]=5'd5; hs_b[6]=5'd2; hs_dst[6]=5'd6;
        hs_op[7]=c_nor1; hs_a[7]=5'd6; hs_b[7]=5'd0; hs_dst[7]=5'd7;
        idx = 0;
        instr_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && idx < 8; cyc++) begin
            instr_op = hs_op[idx]; instr_a = hs_a[idx];
            instr_b = hs_b[idx]; instr_dst = hs_dst[idx];
            if (instr_ready) begin
                hs_acc[idx] = cyc;
                idx++;
            end
            tick();
        end
        instr_valid = 1'b0;
        check("hs_all_accepted", idx, 8);
        for (int i = 1; i < 8; i++)
            check("hs_gap", hs_acc[i] - hs_acc[i-1], (hs_op[i-1] == c_nop) ? 1 : 3);
        wait_idle();
        exp_cnt += 6;
        check("hs_cnt", gate_cnt, exp_cnt);
        check("hs_no_done", done_seen, 0);
        read(5'd7, 1'b0, "hs_c7");

        // In-place operands are consumed with err and no execution
        wr(5'd5, 1'b1);
        wr(5'd6, 1'b0);
        issue(c_nor2, 5'd5, 5'd6, 5'd5);
        check("inplace_busy", busy, 0);
        check("inplace_ready", instr_ready, 1);
        check("inplace_err", err, 1);
        issue(c_nor2, 5'd5, 5'd6, 5'd6);
        check("inplace_b_cnt", gate_cnt, exp_cnt);
        read(5'd5, 1'b1, "inplace_c5");
        read(5'd6, 1'b0, "inplace_c6");
        issue(c_nor1, 5'd5, 5'd0, 5'd8);
        wait_idle();
        exp_cnt += 1;
        check("after_inplace_cnt", gate_cnt, exp_cnt);
        check("err_sticky", err, 1);
        read(5'd8, 1'b0, "after_inplace_c8");

        // Direct write to a source during INIT is ignored
        wr(5'd10, 1'b0);
        issue(c_nor1, 5'd10, 5'd0, 5'd11);
        check("blk_busy", busy, 1);
        wr(5'd10, 1'b1);
        wait_idle();
        exp_cnt += 1;
        read(5'd10, 1'b0, "blk_src");
        read(5'd11, 1'b1, "blk_dst");

        // 5-input parity: four 5-gate XOR stages, result in cell 24
        for (int v = 0; v < 32; v++) begin
            xv = 5'(v);
            for (int k = 0; k < 5; k++) wr(5'(k), xv[k]);
            xor_stage(5'd0,  5'd1, 5'd5);
            xor_stage(5'd9,  5'd2, 5'd10);
            xor_stage(5'd14, 5'd3, 5'd15);
            xor_stage(5'd19, 5'd4, 5'd20);
            issue(c_halt, 5'd0, 5'd0, 5'd0);
            wait_idle();
            exp_cnt += 20;
            read(5'd24, ^xv, "parity");
            check("parity_done", done_seen, v + 1);
        end
        check("parity_cnt", gate_cnt, exp_cnt);
        check("sat_cnt_end", sat_cnt, 15);

        tick();
        tick();
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
